// File: rtl/des_round_core_if.sv
// Handshake and key-schedule bus for des_round_core.
// master: block source, result sink and key-schedule stage; slave: the round core.
// All signals are single-clock and sampled on the rising edge of clk.
interface des_round_core_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        in_decrypt;
  logic [63:0] key_o;
  logic [4:0]  key_cnt;
  logic [47:0] round_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  modport master (
    output in_valid, in_data, in_key, in_decrypt, round_key, out_ready,
    input  in_ready, key_o, key_cnt, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, in_decrypt, round_key, out_ready,
    output in_ready, key_o, key_cnt, out_valid, out_data
  );
endinterface

// File: rtl/des_round_core.sv
// Iterative DES core: one Feistel round per cycle, subkeys fetched from an external key schedule.
// Latency 17 cycles from accepting edge to out_valid; one block in flight, in_ready low until result taken.
// Result held in HOLD until out_ready; macro DES_ROUND_CORE_DECRYPT_EN enables decrypt (reversed key_cnt).
module des_round_core (
  input logic clk,
  input logic rst_n,
  des_round_core_if.slave bus
);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each box is indexed by {row, col} = {b1 b6, b2 b3 b4 b5}.
  localparam logic [3:0] SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  // Bit 63 of every vector is DES bit 1, so DES bit n lives at index width-n.
  function automatic logic [63:0] perm64(input logic [63:0] d, input logic fin);
    logic [63:0] o;
    o = '0;
    for (int i = 1; i <= 64; i++)
      o[6'(64 - i)] = d[6'(64 - (fin ? FP_T[i-1] : IP_T[i-1]))];
    return o;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  six;
    x = '0;
    s = '0;
    p = '0;
    for (int i = 1; i <= 48; i++)
      x[6'(48 - i)] = r[5'(32 - E_T[i-1])];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[6'(47 - 6*b) -: 6];
      s[5'(31 - 4*b) -: 4] = SBOX[3'(b)][{six[5], six[0], six[4:1]}];
    end
    for (int i = 1; i <= 32; i++)
      p[5'(32 - i)] = s[5'(32 - P_T[i-1])];
    return p;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state;
  logic [4:0]  rnd;
  logic [31:0] l_q;
  logic [31:0] r_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [63:0] out_data_q;
  logic [63:0] key_q;
  logic [4:0]  key_cnt_q;
  logic [4:0]  start_cnt;
  logic [4:0]  step_cnt;

`ifdef DES_ROUND_CORE_DECRYPT_EN
  logic dec_q;
`else
  logic unused_decrypt;
  assign unused_decrypt = bus.in_decrypt;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.key_o     = key_q;
  assign bus.key_cnt   = key_cnt_q;

  // Subkey selector: first value at accept, then walk up (encrypt) or down (decrypt).
  always_comb begin
`ifdef DES_ROUND_CORE_DECRYPT_EN
    start_cnt = bus.in_decrypt ? 5'd17 : 5'd2;
    step_cnt  = dec_q ? key_cnt_q - 5'd1 : key_cnt_q + 5'd1;
`else
    start_cnt = 5'd2;
    step_cnt  = key_cnt_q + 5'd1;
`endif
  end

  // Control FSM and datapath: accept, 16 rounds, final permutation cycle, hold for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rnd         <= 5'd0;
      l_q         <= '0;
      r_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      key_q       <= '0;
      key_cnt_q   <= 5'd0;
`ifdef DES_ROUND_CORE_DECRYPT_EN
      dec_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            key_q      <= bus.in_key;
            {l_q, r_q} <= perm64(bus.in_data, 1'b0);
            rnd        <= 5'd1;
            key_cnt_q  <= start_cnt;
            in_ready_q <= 1'b0;
`ifdef DES_ROUND_CORE_DECRYPT_EN
            dec_q      <= bus.in_decrypt;
`endif
            state      <= RUN;
          end
        end
        RUN: begin
          if (rnd == 5'd17) begin
            // Rounds done: swap halves into the final permutation.
            out_data_q  <= perm64({r_q, l_q}, 1'b1);
            out_valid_q <= 1'b1;
            rnd         <= 5'd0;
            state       <= HOLD;
          end else begin
            l_q       <= r_q;
            r_q       <= l_q ^ feistel(r_q, bus.round_key);
            rnd       <= rnd + 5'd1;
            key_cnt_q <= (rnd == 5'd16) ? 5'd0 : step_cnt;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_core.sv
// Self-checking bench for des_round_core with a behavioural key-schedule stage.
// Expected results are queued at accept and compared at the output handshake.
// Decrypt expectations follow DES_ROUND_CORE_DECRYPT_EN.
module tb_des_round_core;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
  localparam logic [63:0] CTZ = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PT2 = 64'h8787878787878787;

  logic        clk;
  logic        rst_n;
  logic [47:0] junk_key;
  int          checks;
  int          failures;
  logic [63:0] exp_q [$];

  des_round_core_if bus ();

  des_round_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] subkey(input logic [63:0] key, input int n);
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] k;
    cd = '0;
    k  = '0;
    for (int i = 1; i <= 56; i++) cd[6'(56 - i)] = key[6'(64 - PC1[i-1])];
    c = cd[55:28];
    d = cd[27:0];
    for (int j = 0; j < n; j++)
      for (int s = 0; s < SHIFTS[j]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    cd = {c, d};
    for (int i = 1; i <= 48; i++) k[6'(48 - i)] = cd[6'(56 - PC2[i-1])];
    return k;
  endfunction

  // Key-schedule stage: subkey K(key_cnt-1) for valid selectors, garbage otherwise.
  always_comb begin
    if (bus.key_cnt >= 5'd2 && bus.key_cnt <= 5'd17)
      bus.round_key = subkey(bus.key_o, int'(bus.key_cnt) - 1);
    else
      bus.round_key = junk_key;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard pop at every output handshake.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check_val("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check_val("out_data", bus.out_data, exp_q.pop_front());
    end
  end

  // Offer one block, check key_o, the key_cnt walk and the 17-cycle latency.
  task automatic run_block(input logic [63:0] key, input logic [63:0] data, input logic dec,
                           input logic [63:0] exp, input string tag);
    int  n;
    bit  eff_dec;
`ifdef DES_ROUND_CORE_DECRYPT_EN
    eff_dec = dec;
`else
    eff_dec = 1'b0;
`endif
    @(negedge clk);
    bus.in_key     = key;
    bus.in_data    = data;
    bus.in_decrypt = dec;
    bus.in_valid   = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_accept_rdy"}, 64'(bus.in_ready), 64'd1);
    exp_q.push_back(exp);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.in_valid = 1'b0;
        check_val({tag, "_key_o"}, bus.key_o, key);
        check_val({tag, "_in_ready_run"}, 64'(bus.in_ready), 64'd0);
      end
      check_val($sformatf("%s_key_cnt_r%0d", tag, k), 64'(bus.key_cnt),
                eff_dec ? 64'(18 - k) : 64'(k + 1));
    end
    @(negedge clk);
    check_val({tag, "_valid_c16"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check_val({tag, "_valid_c17"}, 64'(bus.out_valid), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    checks         = 0;
    failures       = 0;
    clk            = 1'b0;
    rst_n          = 1'b0;
    junk_key       = 48'hDEADBEEFCAFE;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_key     = '0;
    bus.in_decrypt = 1'b0;
    bus.out_ready  = 1'b1;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_val("rst_in_ready",  64'(bus.in_ready), 64'd1);
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_out_data",  bus.out_data, 64'd0);
    check_val("rst_key_o",     bus.key_o, 64'd0);
    check_val("rst_key_cnt",   64'(bus.key_cnt), 64'd0);
    rst_n = 1'b1;

    // Known-answer vectors
    run_block(K1, PT1, 1'b0, CT1, "enc");
`ifdef DES_ROUND_CORE_DECRYPT_EN
    run_block(K1, CT1, 1'b1, PT1, "dec");
`else
    run_block(K1, PT1, 1'b1, CT1, "dec_off");
`endif
    run_block(64'd0, 64'd0, 1'b0, CTZ, "zero");
    run_block(K2, PT2, 1'b0, 64'd0, "k2");

    // Backpressure: hold the result, refuse a second block
    @(negedge clk);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    run_block(K1, PT1, 1'b0, CT1, "bp");
    for (int c = 0; c < 10; c++) begin
      if (c == 2) begin
        bus.in_key   = K2;
        bus.in_data  = PT2;
        bus.in_valid = 1'b1;
      end
      check_val("bp_out_data",  bus.out_data, CT1);
      check_val("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check_val("bp_in_ready",  64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    check_val("bp_key_kept", bus.key_o, K1);
    check_val("bp_key_cnt",  64'(bus.key_cnt), 64'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("bp_rel_valid",   64'(bus.out_valid), 64'd0);
    check_val("bp_rel_ready",   64'(bus.in_ready), 64'd1);
    check_val("bp_rel_key_cnt", 64'(bus.key_cnt), 64'd0);

    // Reset in round 8 aborts the block
    @(negedge clk);
    bus.in_key   = K2;
    bus.in_data  = PT2;
    bus.in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.in_valid = 1'b0;
    end
    check_val("abort_round8_cnt", 64'(bus.key_cnt), 64'd9);
    rst_n = 1'b0;
    #1;
    check_val("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("abort_key_cnt",   64'(bus.key_cnt), 64'd0);
    check_val("abort_in_ready",  64'(bus.in_ready), 64'd1);
    check_val("abort_key_o",     bus.key_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(K1, PT1, 1'b0, CT1, "post_rst");

    // Drain
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
